// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline valid/redirect/load-use/LM-SM sequencing control.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cnt and flush_cnt outputs.
module pipe_hazard_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int REGW     = 3,
  parameter int NREG     = 8,
  parameter int PCSELW   = 3,
  parameter int LU_STAGE = 2,
  parameter int MR_STAGE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [NSTAGE-1:0]        redir_req,
  input  logic [NSTAGE*PCSELW-1:0] redir_sel,
  input  logic                     ld_valid,
  input  logic [REGW-1:0]          ld_rd,
  input  logic [1:0]               use_en,
  input  logic [REGW-1:0]          use_rs1,
  input  logic [REGW-1:0]          use_rs2,
  input  logic                     mr_start,
  input  logic [NREG-1:0]          mr_mask,
  output logic                     pc_en,
  output logic [PCSELW-1:0]        pc_sel,
  output logic [NSTAGE-1:0]        stage_en,
  output logic [NSTAGE-1:0]        stage_flush,
  output logic [NSTAGE-1:0]        stage_valid,
  output logic                     mr_busy,
  output logic [REGW-1:0]          mr_reg,
  output logic [REGW:0]            mr_offset,
  output logic                     mr_last
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              flush_cnt
`endif
);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t state, state_nx;
  logic [NSTAGE-1:0] valid, valid_nx;
  logic [NREG-1:0] rem, rem_nx, cur;
  logic [REGW:0] off, off_nx;
  logic cur_multi, ld_hit, hi_any, ls, raw_issue, raw_hold;
  logic win_any, kill_mr, issue, hold, mr_zero;
  int win;
  always_comb begin
    cur = (state == SEQ) ? rem : mr_mask;
    cur_multi = |(cur & (cur - NREG'(1)));
    ld_hit = ld_valid & valid[LU_STAGE] &
             ((use_en[0] & (use_rs1 == ld_rd)) | (use_en[1] & (use_rs2 == ld_rd)));
    hi_any = 1'b0;
    for (int k = 0; k < NSTAGE; k++)
      if (k > LU_STAGE && redir_req[k] && valid[k]) hi_any = 1'b1;
    // A redirect older than the load consumer cancels the interlock
    ls = ld_hit & ~hi_any;
    raw_issue = ~ls & (|cur) & ((state == SEQ) | (mr_start & valid[MR_STAGE]));
    raw_hold = raw_issue & cur_multi;
    win_any = 1'b0;
    win = 0;
    for (int k = 0; k < NSTAGE; k++)
      if (redir_req[k] && valid[k] && !(k <= LU_STAGE && ls) && !(k <= MR_STAGE && raw_hold)) begin
        win_any = 1'b1;
        win = k;
      end
    kill_mr = win_any & (win > MR_STAGE);
    issue = raw_issue & ~kill_mr;
    hold = issue & cur_multi;
    mr_zero = (state == IDLE) & mr_start & valid[MR_STAGE] & ~ls & ~(|mr_mask);
    stage_en = '1;
    stage_flush = {NSTAGE{~rst_n}};
    for (int i = 0; i < NSTAGE; i++) begin
      stage_en[i] = !((i <= LU_STAGE && ls) || (i <= MR_STAGE && hold));
      stage_flush[i] = stage_flush[i] | (win_any && i <= win) | (ls && i == LU_STAGE + 1) |
                       (mr_zero && i == MR_STAGE + 1);
    end
    pc_en = ~ls & ~hold;
    pc_sel = win_any ? redir_sel[win*PCSELW +: PCSELW] : '0;
    valid_nx = (stage_en & {valid[NSTAGE-2:0], fetch_valid} & ~stage_flush) | (~stage_en & valid);
    mr_busy = (state == SEQ) | issue;
    mr_reg = '0;
    for (int j = NREG - 1; j >= 0; j--)
      if (cur[j]) mr_reg = REGW'(j);
    mr_last = issue & ~cur_multi;
    mr_offset = off;
    state_nx = state;
    rem_nx = rem;
    off_nx = off;
    if (state == SEQ && kill_mr) begin
      state_nx = IDLE;
      rem_nx = '0;
      off_nx = '0;
    end else if (hold) begin
      state_nx = SEQ;
      rem_nx = cur & (cur - NREG'(1));
      off_nx = off + (REGW+1)'(1);
    end else if (issue) begin
      state_nx = IDLE;
      rem_nx = '0;
      off_nx = '0;
    end
  end
  assign stage_valid = valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      off <= '0;
      valid <= '0;
    end else begin
      state <= state_nx;
      rem <= rem_nx;
      off <= off_nx;
      valid <= valid_nx;
    end
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] kill_n;
  logic [16:0] flush_sum;
  always_comb begin
    kill_n = '0;
    for (int i = 0; i < NSTAGE; i++)
      if (win_any && i < win && valid[i]) kill_n = kill_n + 16'd1;
    flush_sum = {1'b0, flush_cnt} + {1'b0, kill_n};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= (!pc_en && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
      flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    int          id;
    logic        pe;
    logic [2:0]  ps;
    logic [4:0]  en;
    logic [4:0]  fl;
    logic [4:0]  vl;
    logic        bz;
    logic [3:0]  off;
    logic        cp;
    logic [15:0] sc;
    logic [15:0] fc;
  } ctl_t;
  typedef struct packed {
    logic [2:0] r;
    logic [3:0] off;
    logic       last;
  } uop_t;
  localparam logic [14:0] SEL = 15'b110_101_001_011_111;
  logic clk = 1'b0, rst_n = 1'b0, fetch_valid = 1'b0, ld_valid = 1'b0, mr_start = 1'b0;
  logic [4:0] redir_req = '0;
  logic [14:0] redir_sel = SEL;
  logic [2:0] ld_rd = '0, use_rs1 = '0, use_rs2 = '0;
  logic [1:0] use_en = '0;
  logic [7:0] mr_mask = '0;
  logic pc_en, mr_busy, mr_last;
  logic [2:0] pc_sel, mr_reg;
  logic [4:0] stage_en, stage_flush, stage_valid;
  logic [3:0] mr_offset;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  ctl_t cq[$];
  uop_t uq[$];
  ctl_t c;
  uop_t u;
  int tests = 0, fails = 0, nid = 0;
  logic done = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .redir_req(redir_req),
    .redir_sel(redir_sel), .ld_valid(ld_valid), .ld_rd(ld_rd), .use_en(use_en),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .mr_start(mr_start), .mr_mask(mr_mask),
    .pc_en(pc_en), .pc_sel(pc_sel), .stage_en(stage_en), .stage_flush(stage_flush),
    .stage_valid(stage_valid), .mr_busy(mr_busy), .mr_reg(mr_reg), .mr_offset(mr_offset),
    .mr_last(mr_last)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  task automatic expc(input logic pe, input logic [2:0] ps, input logic [4:0] en, input logic [4:0] fl,
                      input logic [4:0] vl, input logic bz, input logic [3:0] off);
    cq.push_back('{nid, pe, ps, en, fl, vl, bz, off, 1'b0, 16'd0, 16'd0});
    nid++;
  endtask
  task automatic expp(input logic [15:0] sc, input logic [15:0] fc);
    cq[cq.size()-1].cp = 1'b1;
    cq[cq.size()-1].sc = sc;
    cq[cq.size()-1].fc = fc;
  endtask
  task automatic expu(input logic [2:0] r, input logic [3:0] off, input logic last);
    uq.push_back('{r, off, last});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic ld_hazard(input logic on);
    ld_valid = on;
    ld_rd = 3'd3;
    use_en = 2'b01;
    use_rs1 = 3'd3;
    use_rs2 = 3'd6;
  endtask
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      c = cq.pop_front();
      tests++;
      if ({pc_en, pc_sel, stage_en, stage_flush, stage_valid, mr_busy, mr_offset} !==
          {c.pe, c.ps, c.en, c.fl, c.vl, c.bz, c.off}) begin
        fails++;
        $display("FAIL ctl#%0d got pe=%b sel=%0d en=%b fl=%b v=%b busy=%b off=%0d need pe=%b sel=%0d en=%b fl=%b v=%b busy=%b off=%0d",
                 c.id, pc_en, pc_sel, stage_en, stage_flush, stage_valid, mr_busy, mr_offset,
                 c.pe, c.ps, c.en, c.fl, c.vl, c.bz, c.off);
      end
`ifdef HAZ_PERF_CNT_EN
      if (c.cp) begin
        tests++;
        if ({stall_cnt, flush_cnt} !== {c.sc, c.fc}) begin
          fails++;
          $display("FAIL perf#%0d got stall=%h flush=%h need stall=%h flush=%h",
                   c.id, stall_cnt, flush_cnt, c.sc, c.fc);
        end
      end
`endif
    end
    if (rst_n === 1'b1 && mr_busy === 1'b1 && stage_en[2] === 1'b1 && stage_flush[2] === 1'b0) begin
      tests++;
      if (uq.size() == 0) begin
        fails++;
        $display("FAIL uop unexpected got reg=%0d off=%0d last=%b need none", mr_reg, mr_offset, mr_last);
      end else begin
        u = uq.pop_front();
        if ({mr_reg, mr_offset, mr_last} !== {u.r, u.off, u.last}) begin
          fails++;
          $display("FAIL uop got reg=%0d off=%0d last=%b need reg=%0d off=%0d last=%b",
                   mr_reg, mr_offset, mr_last, u.r, u.off, u.last);
        end
      end
    end
    if (done) begin
      tests += 2;
      if (cq.size() != 0) begin
        fails++;
        $display("FAIL ctl_drain got %0d pending need 0", cq.size());
      end
      if (uq.size() != 0) begin
        fails++;
        $display("FAIL uop_drain got %0d missing micro-ops need 0", uq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end
  initial begin
    step();
    expc(1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0); step();
    rst_n = 1'b1;
    fetch_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expc(1, 0, 5'b11111, 5'b00000, 5'((1 << i) - 1), 0, 0); step();
    end
    redir_req = 5'b00110;
    expc(1, 3'd1, 5'b11111, 5'b00111, 5'b11111, 0, 0); step();
    redir_req = '0;
    expc(1, 0, 5'b11111, 5'b00000, 5'b11000, 0, 0); step();
    expc(1, 0, 5'b11111, 5'b00000, 5'b10001, 0, 0); step();
    run(5);
    ld_hazard(1);
    expc(0, 0, 5'b11000, 5'b01000, 5'b11111, 0, 0); step();
    ld_hazard(0);
    expc(1, 0, 5'b11111, 5'b00000, 5'b10111, 0, 0); expp(16'd1, 16'd2); step();
    run(5);
    ld_hazard(1);
    redir_req = 5'b10000;
    expc(1, 3'd6, 5'b11111, 5'b11111, 5'b11111, 0, 0); step();
    ld_hazard(0);
    redir_req = '0;
    expc(1, 0, 5'b11111, 5'b00000, 5'b00000, 0, 0); step();
    run(5);
    ld_hazard(1);
    redir_req = 5'b00010;
    expc(0, 0, 5'b11000, 5'b01000, 5'b11111, 0, 0); step();
    ld_hazard(0);
    expc(1, 3'd3, 5'b11111, 5'b00011, 5'b10111, 0, 0); step();
    redir_req = '0;
    run(5);
    mr_start = 1'b1;
    mr_mask = 8'b1010_0101;
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 0); expu(0, 0, 0); step();
    mr_start = 1'b0;
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 1); expu(2, 1, 0); step();
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 2); expu(5, 2, 0); step();
    expc(1, 0, 5'b11111, 5'b00000, 5'b11111, 1, 3); expu(7, 3, 1); step();
    expc(1, 0, 5'b11111, 5'b00000, 5'b11111, 0, 0); step();
    mr_start = 1'b1;
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 0); expu(0, 0, 0); step();
    mr_start = 1'b0;
    redir_req = 5'b01000;
    expc(1, 3'd5, 5'b11111, 5'b01111, 5'b11111, 1, 1); step();
    redir_req = '0;
    expc(1, 0, 5'b11111, 5'b00000, 5'b10000, 0, 0); step();
    run(5);
    mr_start = 1'b1;
    mr_mask = 8'b0000_0000;
    expc(1, 0, 5'b11111, 5'b00100, 5'b11111, 0, 0); step();
    mr_start = 1'b0;
    expc(1, 0, 5'b11111, 5'b00000, 5'b11011, 0, 0); step();
    run(5);
    mr_start = 1'b1;
    mr_mask = 8'b0001_0000;
    expc(1, 0, 5'b11111, 5'b00000, 5'b11111, 1, 0); expu(4, 0, 1); step();
    mr_start = 1'b0;
    expc(1, 0, 5'b11111, 5'b00000, 5'b11111, 0, 0); step();
    mr_start = 1'b1;
    mr_mask = 8'b0000_0110;
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 0); expu(1, 0, 0); step();
    mr_start = 1'b0;
    ld_hazard(1);
    expc(0, 0, 5'b11000, 5'b01000, 5'b11111, 1, 1); step();
    ld_hazard(0);
    expc(1, 0, 5'b11111, 5'b00000, 5'b10111, 1, 1); expu(2, 1, 1); step();
    expc(1, 0, 5'b11111, 5'b00000, 5'b01111, 0, 0); step();
    run(5);
    mr_start = 1'b1;
    mr_mask = 8'b1010_0101;
    expc(0, 0, 5'b11100, 5'b00000, 5'b11111, 1, 0); expu(0, 0, 0); step();
    mr_start = 1'b0;
    rst_n = 1'b0;
    expc(1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0); step();
    rst_n = 1'b1;
    expc(1, 0, 5'b11111, 5'b00000, 5'b00000, 0, 0); step();
`ifdef HAZ_PERF_CNT_EN
    run(5);
    ld_hazard(1);
    run(70000);
    expc(0, 0, 5'b11000, 5'b01000, 5'b00111, 0, 0); expp(16'hFFFF, 16'd0); step();
    ld_hazard(0);
`endif
    done = 1'b1;
  end
endmodule
